alu_multicycle: RTL and testbench

Parametrised successor to the single-cycle 16-bit ALU, for the multi-cycle datapath.
- Adds registered outputs, a start/busy/done handshake, arithmetic shift, signed compare, and iterative unsigned multiply/divide with a high result word.
- Sits between the register-file read ports and the writeback mux.
- Controlled by the multi-cycle control FSM, which holds the datapath while busy=1.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_muldiv_iter.sv | 84 ++++++++
 rtl/alu_multicycle.sv | 179 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the multi-cycle ALU: operation codes,
//            control-FSM state encoding and the illegal-op boundary.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes (4-bit op field)
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    // First illegal code; every code from here upward is illegal.
    localparam logic [3:0] ILLEGAL_OP = 4'd10;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_illegal(input logic [3:0] code);
        return (code >= ILLEGAL_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_iter
// Purpose  : Iterative unsigned multiply (shift-add) / restoring divide.
//            One bit per step, WIDTH steps per operation.
// Ports    : clk, rst     - clock, async active-high reset
//            load         - capture operands a/b and mode, clear counter
//            is_div       - mode captured on load (1 = divide, 0 = multiply)
//            step         - perform one iteration
//            a, b         - multiplier/multiplicand or dividend/divisor
//            last         - current step is the final iteration
//            lo_next      - low word after this step (product low / quotient)
//            hi_next      - high word after this step (product high / remainder)
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] lo;        // multiplier being consumed / dividend shifting into quotient
    logic [WIDTH-1:0] hi;        // product accumulator / partial remainder
    logic [WIDTH-1:0] opb;       // multiplicand / divisor
    logic             div_mode;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             q_bit;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {hi, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        // A clear borrow bit means the trial subtraction fits.
        q_bit     = ~div_diff[WIDTH];
        if (div_mode) begin
            hi_next = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], q_bit};
        end else begin
            // Shift the whole {carry,hi,lo} right by one; lo[0] is consumed.
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign last = (count == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            lo       <= '0;
            hi       <= '0;
            opb      <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            count    <= '0;
            lo       <= a;
            hi       <= '0;
            opb      <= b;
            div_mode <= is_div;
        end else if (step) begin
            count    <= count + 1'b1;
            lo       <= lo_next;
            hi       <= hi_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Multi-cycle ALU with registered outputs and start/busy/done
//            handshake. Logic/arith/shift/compare complete in one cycle;
//            unsigned multiply and divide iterate for WIDTH cycles.
// Ports    : clk, rst   - clock, async active-high reset
//            start      - request, sampled only in IDLE
//            op         - operation code (alu_pkg OP_*)
//            inA, inB   - operands
//            shamt      - shift amount for SLL/SRL/SRA
//            busy       - multiply/divide in progress
//            done       - one-cycle completion pulse
//            result     - primary result (low product / quotient)
//            resultHi   - high product / remainder, 0 otherwise
//            zero       - result == 0
//            err        - divide by zero or illegal op
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   inA,
    input  logic [WIDTH-1:0]   inB,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   resultHi,
    output logic               zero,
    output logic               err
);

    state_t           state;
    state_t           next_state;

    logic             iter_load;
    logic             iter_is_div;
    logic             iter_step;
    logic             iter_last;
    logic [WIDTH-1:0] iter_lo_next;
    logic [WIDTH-1:0] iter_hi_next;

    logic [WIDTH-1:0] alu_out;
    logic             alu_illegal;

    logic             write_res;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             res_err;

    // ------------------------------------------------------------------
    // Single-cycle operations
    // ------------------------------------------------------------------
    always_comb begin
        alu_out     = '0;
        alu_illegal = is_illegal(op);
        case (op)
            OP_AND:  alu_out = inA & inB;
            OP_OR:   alu_out = inA | inB;
            OP_ADD:  alu_out = inA + inB;
            OP_SUB:  alu_out = inA - inB;
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
            OP_SLL:  alu_out = inA << shamt;
            OP_SRL:  alu_out = inA >> shamt;
            OP_SRA:  alu_out = $signed(inA) >>> shamt;
            default: alu_out = '0;   // MULU/DIVU go through the iterator; illegal yields 0
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative multiply / divide engine
    // ------------------------------------------------------------------
    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (iter_load),
        .is_div  (iter_is_div),
        .step    (iter_step),
        .a       (inA),
        .b       (inB),
        .last    (iter_last),
        .lo_next (iter_lo_next),
        .hi_next (iter_hi_next)
    );

    // ------------------------------------------------------------------
    // Control FSM: next state and result-write selection
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        iter_load   = 1'b0;
        iter_is_div = 1'b0;
        iter_step   = 1'b0;
        write_res   = 1'b0;
        res_lo      = '0;
        res_hi      = '0;
        res_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op == OP_MULU) begin
                        iter_load  = 1'b1;
                        next_state = ST_MUL;
                    end else if (op == OP_DIVU) begin
                        if (inB != '0) begin
                            iter_load   = 1'b1;
                            iter_is_div = 1'b1;
                            next_state  = ST_DIV;
                        end else begin
                            // Divide by zero finishes immediately with a saturated quotient.
                            write_res  = 1'b1;
                            res_lo     = '1;
                            res_hi     = inA;
                            res_err    = 1'b1;
                            next_state = ST_DONE;
                        end
                    end else begin
                        write_res  = 1'b1;
                        res_lo     = alu_out;
                        res_err    = alu_illegal;
                        next_state = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                iter_step = 1'b1;
                if (iter_last) begin
                    // Capture the step's output directly so no extra cycle is spent.
                    write_res  = 1'b1;
                    res_lo     = iter_lo_next;
                    res_hi     = iter_hi_next;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            result   <= '0;
            resultHi <= '0;
            zero     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            if (write_res) begin
                result   <= res_lo;
                resultHi <= res_hi;
                zero     <= (res_lo == '0);
                err      <= res_err;
            end
        end
    end

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Purpose  : Scoreboard testbench for alu_multicycle (WIDTH=16 main instance,
//            WIDTH=32 instance for the wide multiply case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         e;
        int           lat;        // edges from start-sample edge to done-observed edge
        int           busy_cyc;   // cycles busy is expected high
        int           start_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic [3:0]   shamt = '0;
    logic         busy, done, zero, err;
    logic [W-1:0] result, resultHi;

    logic         start32 = 1'b0;
    logic [3:0]   op32 = '0;
    logic [31:0]  a32 = '0;
    logic [31:0]  b32 = '0;
    logic [4:0]   sh32 = '0;
    logic         busy32, done32, zero32, err32;
    logic [31:0]  result32, resultHi32;

    int   errors = 0;
    int   checks = 0;
    int   edge_cnt = 0;
    int   busy_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    alu_multicycle #(.WIDTH(W), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .inA(inA), .inB(inB),
        .shamt(shamt), .busy(busy), .done(done), .result(result),
        .resultHi(resultHi), .zero(zero), .err(err)
    );

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op32), .inA(a32), .inB(b32),
        .shamt(sh32), .busy(busy32), .done(done32), .result(result32),
        .resultHi(resultHi32), .zero(zero32), .err(err32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: plain arithmetic on the operation definitions.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [3:0] sh);
        exp_t        r;
        logic [31:0] p;
        r.lo = '0; r.hi = '0; r.e = 1'b0; r.lat = 1; r.busy_cyc = 0; r.start_edge = 0;
        case (o)
            4'd0: r.lo = a & b;
            4'd1: r.lo = a | b;
            4'd2: r.lo = a + b;
            4'd3: r.lo = a - b;
            4'd4: r.lo = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd5: r.lo = a << sh;
            4'd6: r.lo = a >> sh;
            4'd7: r.lo = W'($signed(a) >>> sh);
            4'd8: begin
                p = 32'(a) * 32'(b);
                r.lo = p[15:0]; r.hi = p[31:16]; r.lat = W + 1; r.busy_cyc = W;
            end
            4'd9: begin
                if (b == 0) begin
                    r.lo = 16'hFFFF; r.hi = a; r.e = 1'b1;
                end else begin
                    r.lo = a / b; r.hi = a % b; r.lat = W + 1; r.busy_cyc = W;
                end
            end
            default: r.e = 1'b1;
        endcase
        r.z = (r.lo == 0);
        return r;
    endfunction

    // Monitor: pops an expectation whenever done is presented.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt = busy_cnt + 1;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result",   64'(result),   64'(e.lo));
                    chk("resultHi", 64'(resultHi), 64'(e.hi));
                    chk("zero",     64'(zero),     64'(e.z));
                    chk("err",      64'(err),      64'(e.e));
                    chk("latency",  64'(edge_cnt + 1 - e.start_edge), 64'(e.lat));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.busy_cyc));
                    chk("busy_at_done", 64'(busy), 64'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sh, input bit wait_done, input bit poke);
        exp_t e;
        @(negedge clk);
        op = o; inA = a; inB = b; shamt = sh; start = 1'b1;
        e = model(o, a, b, sh);
        e.start_edge = edge_cnt + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        inA = W'($urandom); inB = W'($urandom); op = 4'($urandom); shamt = 4'($urandom);
        if (poke) begin
            // A request during busy must be ignored entirely.
            repeat (3) @(negedge clk);
            start = 1'b1; op = 4'd2; inA = 16'h1111; inB = 16'h2222;
            @(negedge clk);
            start = 1'b0;
        end
        if (wait_done) wait_idle();
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b);
        int s;
        int n;
        @(negedge clk);
        op32 = 4'd8; a32 = a; b32 = b; start32 = 1'b1;
        s = edge_cnt + 1;
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        n = 0;
        while (!done32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w32_done_seen", 64'(done32), 64'd1);
        chk("w32_latency", 64'(edge_cnt + 1 - s), 64'd33);
        chk("w32_resultHi", 64'(resultHi32), 64'h1);
        chk("w32_result", 64'(result32), 64'h0);
        chk("w32_err", 64'(err32), 64'd0);
    endtask

    initial begin
        #1;
        chk("reset_outputs", 64'({busy, done, zero, err, result, resultHi}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        issue(4'd2, 16'h7FFF, 16'h0001, 4'd0, 1, 0);   // ADD -> 0x8000
        issue(4'd3, 16'h0005, 16'h0005, 4'd0, 1, 0);   // SUB -> 0, zero
        issue(4'd7, 16'h8000, 16'h0000, 4'd3, 1, 0);   // SRA -> 0xF000
        issue(4'd4, 16'hFFFF, 16'h0001, 4'd0, 1, 0);   // SLT -> 1
        issue(4'd8, 16'hFFFF, 16'hFFFF, 4'd0, 1, 1);   // MULU with ignored re-start
        issue(4'd9, 16'd100,  16'd7,    4'd0, 1, 0);   // DIVU 14 r 2
        issue(4'd9, 16'h1234, 16'h0000, 4'd0, 1, 0);   // DIVU by zero
        issue(4'd12, 16'hABCD, 16'h1234, 4'd0, 1, 0);  // illegal
        issue(4'd9, 16'd100,  16'd7,    4'd0, 1, 0);   // nonzero outputs before reset test

        // Reset mid-multiply: outputs clear at once, no done follows.
        issue(4'd8, 16'h1234, 16'h5678, 4'd0, 0, 0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midop_reset_outputs", 64'({busy, done, zero, err, result, resultHi}), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        issue(4'd2, 16'h0102, 16'h0304, 4'd0, 1, 0);   // ADD after reset

        // Randomized traffic, with divide-by-zero and boundary operands mixed in
        for (int i = 0; i < 60; i++) begin
            logic [3:0]   o;
            logic [W-1:0] a, b;
            o = 4'($urandom_range(0, 15));
            a = W'($urandom);
            b = W'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 16'hFFFF;
                2: b = 16'h0001;
                default: ;
            endcase
            issue(o, a, b, 4'($urandom), 1, 0);
        end

        run32(32'h0001_0000, 32'h0001_0000);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
